read_burst_sequencer: RTL and testbench

- Controller that sequences the DDR read-capture datapath.
- Accepts one READ-issued pulse from the command FSM and waits the CAS latency plus the capture-stage delay.
- Samples BL/2 consecutive 2*BW-bit words from the DDR read capture buffer and assembles them into one BW*BL-bit line.
- Holds the line with a valid/ack handshake toward the CPU-side interface; one outstanding read at a time.

---
 rtl/read_burst_sequencer.sv | 98 +++++++++
 tb/tb_read_burst_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/read_burst_sequencer.sv
// read_burst_sequencer: waits CL+CAP_DLY after a READ, assembles BL/2 capture words into one line, holds it for valid/ack.
// Optional ack timeout in HOLD when RD_ACK_TIMEOUT_EN is defined.
module read_burst_sequencer #(
  parameter int BW      = 8,
  parameter int BL      = 8,
  parameter int CL      = 5,
  parameter int CAP_DLY = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            rd_cmd,
  output logic            rd_cmd_ready,
  input  logic [2*BW-1:0] cap_data,
  output logic [BW*BL-1:0] rd_data,
  output logic            rd_valid,
  input  logic            rd_ack,
  output logic            busy,
  output logic            cmd_err,
  output logic            rd_timeout
);
  localparam int LAT = CL + CAP_DLY;
  localparam int NW  = BL / 2;
  localparam int LW  = $clog2(LAT + 1);
  localparam int BCW = NW > 1 ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_CL, CAPTURE, HOLD} state_t;

  state_t         state;
  logic [LW-1:0]  lat_cnt;
  logic [BCW-1:0] beat;
  logic           to_hit;

  if (BL < 2 || BL % 2 != 0 || CL < 1 || CAP_DLY < 0 || TIMEOUT < 1) begin : g_bad_params
    $error("read_burst_sequencer: illegal parameter set");
  end

  assign rd_cmd_ready = state == IDLE;

`ifdef RD_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  assign to_hit = to_cnt == TW'(TIMEOUT - 1);
  // to_cnt sits at zero outside HOLD, so it is already clear on entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt     <= '0;
      rd_timeout <= 1'b0;
    end else begin
      to_cnt     <= state == HOLD ? to_cnt + 1'b1 : '0;
      rd_timeout <= state == HOLD && !rd_ack && to_hit;
    end
  end
`else
  assign to_hit     = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      beat     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      if (rd_cmd && state != IDLE) cmd_err <= 1'b1;
      case (state)
        IDLE: if (rd_cmd) begin
          busy    <= 1'b1;
          lat_cnt <= LW'(LAT - 1);
          beat    <= '0;
          state   <= LAT > 1 ? WAIT_CL : CAPTURE;
        end
        WAIT_CL: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LW'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          rd_data[int'(beat)*2*BW +: 2*BW] <= cap_data;
          beat <= beat + 1'b1;
          if (beat == BCW'(NW - 1)) begin
            state    <= HOLD;
            rd_valid <= 1'b1;
          end
        end
        HOLD: if (rd_ack || to_hit) begin
          state    <= IDLE;
          rd_valid <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_read_burst_sequencer.sv
// tb_read_burst_sequencer: two configurations (default and CL=1/CAP_DLY=0/BL=2) checked against an edge-counting model.
module tb_read_burst_sequencer;
`ifdef RD_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_cmd = 1'b0;
  logic        rd_ack = 1'b0;
  logic [15:0] cap_data = '0;
  logic        rdy[2], vld[2], bsy[2], err[2], tmo[2];
  logic [63:0] data0;
  logic [15:0] data1;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  read_burst_sequencer #(.BW(8), .BL(8), .CL(5), .CAP_DLY(1), .TIMEOUT(TO)) dut0 (
    .clock(clock), .reset_n(reset_n), .rd_cmd(rd_cmd), .rd_cmd_ready(rdy[0]),
    .cap_data(cap_data), .rd_data(data0), .rd_valid(vld[0]), .rd_ack(rd_ack),
    .busy(bsy[0]), .cmd_err(err[0]), .rd_timeout(tmo[0]));

  read_burst_sequencer #(.BW(8), .BL(2), .CL(1), .CAP_DLY(0), .TIMEOUT(TO)) dut1 (
    .clock(clock), .reset_n(reset_n), .rd_cmd(rd_cmd), .rd_cmd_ready(rdy[1]),
    .cap_data(cap_data), .rd_data(data1), .rd_valid(vld[1]), .rd_ack(rd_ack),
    .busy(bsy[1]), .cmd_err(err[1]), .rd_timeout(tmo[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: edges since the accepted READ; words land at edges LAT..LAT+NW-1.
  function automatic int lat(input int k); return k == 0 ? 6 : 1; endfunction
  function automatic int nwords(input int k); return k == 0 ? 4 : 1; endfunction

  int          mt[2] = '{-1, -1};
  bit          mv[2] = '{0, 0};
  logic [63:0] ml[2] = '{64'd0, 64'd0};
  bit          merr[2] = '{0, 0};
  int          hc[2] = '{0, 0};
  bit          mto[2] = '{0, 0};

  initial forever begin
    @(posedge clock or negedge reset_n);
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        mt[k] = -1; mv[k] = 0; ml[k] = '0; merr[k] = 0; hc[k] = 0; mto[k] = 0;
      end else begin
        bit idle;
        idle = mt[k] < 0 && !mv[k];
        mto[k] = 0;
        if (rd_cmd && !idle) merr[k] = 1;
        if (mv[k]) begin
          if (rd_ack) mv[k] = 0;
          else begin
            hc[k]++;
            if (TO_EN && hc[k] == TO) begin mv[k] = 0; mto[k] = 1; end
          end
        end else if (mt[k] >= 0) begin
          mt[k]++;
          if (mt[k] >= lat(k)) ml[k][(mt[k] - lat(k)) * 16 +: 16] = cap_data;
          if (mt[k] == lat(k) + nwords(k) - 1) begin mv[k] = 1; mt[k] = -1; hc[k] = 0; end
        end else if (rd_cmd) mt[k] = 0;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) for (int k = 0; k < 2; k++) begin
      bit idle;
      idle = mt[k] < 0 && !mv[k];
      chk($sformatf("cfg%0d rd_valid", k), vld[k], mv[k]);
      chk($sformatf("cfg%0d rd_cmd_ready", k), rdy[k], idle);
      chk($sformatf("cfg%0d busy", k), bsy[k], !idle);
      chk($sformatf("cfg%0d cmd_err", k), err[k], merr[k]);
      chk($sformatf("cfg%0d rd_timeout", k), tmo[k], mto[k]);
      chk($sformatf("cfg%0d rd_data", k), k == 0 ? data0 : {48'd0, data1}, ml[k]);
    end
  end

  task automatic step(input bit c, input bit a, input logic [15:0] d);
    rd_cmd = c; rd_ack = a; cap_data = d;
    @(posedge clock); #1;
    rd_cmd = 0; rd_ack = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1;
  endtask

  // READ at edge 0 (plus optional extra command edge); words at edges 6..9
  task automatic burst(input logic [15:0] w0, w1, w2, w3, input int extra, output bit pre);
    logic [15:0] w[4];
    w = '{w0, w1, w2, w3};
    pre = 0;
    for (int e = 0; e <= 9; e++) begin
      if (e == 9) pre = vld[0];
      step(e == 0 || e == extra, 0, e >= 6 ? w[e-6] : 16'($urandom));
    end
  endtask

  initial begin
    bit pre;
    int first, pulses;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    chk("reset ready", rdy[0], 1);
    chk("reset valid", vld[0], 0);
    chk("reset data", data0, 0);

    burst(16'h1100, 16'h3322, 16'h5544, 16'h7766, -1, pre);
    chk("t1 valid before edge9", pre, 0);
    chk("t1 valid", vld[0], 1);
    chk("t1 data", data0, 64'h7766_5544_3322_1100);

    repeat (20) step(0, 0, 16'($urandom));
    chk("hold valid", vld[0], !TO_EN);
    chk("hold data", data0, 64'h7766_5544_3322_1100);
    step(0, 1, 16'($urandom));
    chk("ack valid", vld[0], 0);
    chk("ack ready", rdy[0], 1);

    burst(16'h0101, 16'h0202, 16'h0303, 16'h0404, -1, pre);
    first = 0; pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 16'($urandom));
      if (tmo[0]) begin pulses++; if (first == 0) first = i; end
    end
    chk("timeout edge", first, TO_EN ? TO : 0);
    chk("timeout pulses", pulses, TO_EN ? 1 : 0);
    chk("timeout valid", vld[0], !TO_EN);
    chk("timeout ready", rdy[0], TO_EN);
    step(0, 1, 16'($urandom));

    burst(16'haa01, 16'hbb02, 16'hcc03, 16'hdd04, 3, pre);
    chk("t3 cmd_err", err[0], 1);
    chk("t3 data", data0, 64'hdd04_cc03_bb02_aa01);
    step(0, 1, 16'($urandom));
    chk("t3 cmd_err sticky", err[0], 1);

    step(1, 0, 16'($urandom));
    repeat (7) step(0, 0, 16'($urandom));
    reset_n = 0;
    #1;
    chk("t4 valid", vld[0], 0);
    chk("t4 data", data0, 0);
    chk("t4 ready", rdy[0], 1);
    chk("t4 cmd_err", err[0], 0);
    #2 reset_n = 1;
    burst(16'h1357, 16'h2468, 16'h9abc, 16'hdef0, -1, pre);
    chk("t4 new data", data0, 64'hdef0_9abc_2468_1357);
    step(0, 1, 16'($urandom));

    burst(16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d, -1, pre);
    chk("b2b first data", data0, 64'h0d0d_0c0c_0b0b_0a0a);
    step(0, 1, 16'($urandom));
    burst(16'h5a5a, 16'h6b6b, 16'h7c7c, 16'h8d8d, -1, pre);
    chk("b2b second data", data0, 64'h8d8d_7c7c_6b6b_5a5a);
    chk("b2b cmd_err", err[0], 0);
    step(0, 1, 16'($urandom));

    do_reset();
    step(1, 0, 16'($urandom));
    step(0, 0, 16'hbeef);
    chk("cfg1 valid", vld[1], 1);
    chk("cfg1 data", data1, 16'hbeef);
    step(0, 1, 16'($urandom));
    step(1, 0, 16'($urandom));
    step(0, 0, 16'h1234);
    chk("cfg1 b2b valid", vld[1], 1);
    chk("cfg1 b2b data", data1, 16'h1234);
    chk("cfg1 cmd_err", err[1], 0);
    step(0, 1, 16'($urandom));

    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) do_reset();
      step($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
